// File: rtl/bios_loader.sv
// bios_loader: copies WORD_COUNT words from a combinationally read BIOS ROM
// into instruction RAM while holding the CPU, then releases it.
// Optional checksum stage compiled in with `define BIOS_LOADER_CHECKSUM_EN:
// the ROM word at index WORD_COUNT must equal the modulo-2^DATA_WIDTH sum of
// all copied words, otherwise chk_err is raised and the CPU stays held.
module bios_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int WORD_COUNT     = 255,
  parameter int DEST_BASE      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_q,
  output logic                      ram_we,
  input  logic                      ram_ready,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_data,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      chk_err
);

  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_IDX  = ROM_ADDR_WIDTH'(WORD_COUNT);
  localparam logic [RAM_ADDR_WIDTH-1:0] BASE_ADDR = RAM_ADDR_WIDTH'(DEST_BASE);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_LOAD,
`ifdef BIOS_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_IDLE
  } state_t;

  state_t                      r_state, w_state;
  // r_rom_addr doubles as idx: the index of the next ROM word to fetch
  logic [ROM_ADDR_WIDTH-1:0]   r_rom_addr, w_rom_addr;
  logic                        r_ram_we, w_ram_we;
  logic [RAM_ADDR_WIDTH-1:0]   r_ram_addr, w_ram_addr;
  logic [DATA_WIDTH-1:0]       r_ram_data, w_ram_data;
  logic                        r_cpu_hold, w_cpu_hold;
  logic                        r_done, w_done;
  logic                        w_accept;
  logic [RAM_ADDR_WIDTH-1:0]   w_dest;
`ifdef BIOS_LOADER_CHECKSUM_EN
  logic                        r_chk_err, w_chk_err;
  logic [DATA_WIDTH-1:0]       r_acc, w_acc;
`endif

  assign w_accept = r_ram_we & ram_ready;
  assign w_dest   = BASE_ADDR + RAM_ADDR_WIDTH'(r_rom_addr);

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_state    = r_state;
    w_rom_addr = r_rom_addr;
    w_ram_we   = r_ram_we;
    w_ram_addr = r_ram_addr;
    w_ram_data = r_ram_data;
    w_cpu_hold = r_cpu_hold;
    w_done     = r_done;
`ifdef BIOS_LOADER_CHECKSUM_EN
    w_chk_err  = r_chk_err;
    w_acc      = w_accept ? r_acc + r_ram_data : r_acc;
`endif
    case (r_state)
      ST_BOOT: begin
        w_state    = ST_LOAD;
        w_rom_addr = '0;
      end
      ST_LOAD: begin
        // Fetch runs one word ahead of the write port; once every word has
        // been fetched, the final acceptance ends the copy.
        if (w_accept && (r_rom_addr == LAST_IDX)) begin
          w_ram_we = 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
          w_state  = ST_CHECK;
`else
          w_state    = ST_DONE;
          w_done     = 1'b1;
          w_cpu_hold = 1'b0;
`endif
        end else if ((!r_ram_we || ram_ready) && (r_rom_addr != LAST_IDX)) begin
          w_ram_we   = 1'b1;
          w_ram_data = rom_q;
          w_ram_addr = w_dest;
          w_rom_addr = r_rom_addr + 1'b1;
        end
      end
`ifdef BIOS_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        w_state = ST_DONE;
        w_done  = 1'b1;
        if (rom_q != r_acc) begin
          w_chk_err = 1'b1;
        end else begin
          w_cpu_hold = 1'b0;
        end
      end
`endif
      ST_DONE, ST_IDLE: begin
        if (start) begin
          w_state    = ST_LOAD;
          w_done     = 1'b0;
          w_cpu_hold = 1'b1;
          w_rom_addr = '0;
`ifdef BIOS_LOADER_CHECKSUM_EN
          w_chk_err  = 1'b0;
          w_acc      = '0;
`endif
        end else if (r_state == ST_DONE) begin
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_BOOT;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_rom_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
`ifdef BIOS_LOADER_CHECKSUM_EN
      r_chk_err  <= 1'b0;
      r_acc      <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_rom_addr <= w_rom_addr;
      r_ram_we   <= w_ram_we;
      r_ram_addr <= w_ram_addr;
      r_ram_data <= w_ram_data;
      r_cpu_hold <= w_cpu_hold;
      r_done     <= w_done;
`ifdef BIOS_LOADER_CHECKSUM_EN
      r_chk_err  <= w_chk_err;
      r_acc      <= w_acc;
`endif
    end
  end

  assign rom_addr = r_rom_addr;
  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign cpu_hold = r_cpu_hold;
  assign done     = r_done;
`ifdef BIOS_LOADER_CHECKSUM_EN
  assign chk_err  = r_chk_err;
`else
  assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bios_loader.sv
// Bench for bios_loader: two instances (RAM base 0 and base 1022, 4 words)
// share one ROM image. Expected writes, completion time and checksum status
// are computed from the ROM contents and the observed number of stall cycles.
module tb_bios_loader;

  localparam int NW = 4;
`ifdef BIOS_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr [2];
  logic [31:0] rom_q    [2];
  logic        ram_we   [2];
  logic        ready    [2];
  logic [9:0]  ram_addr [2];
  logic [31:0] ram_data [2];
  logic        cpu_hold [2];
  logic        done     [2];
  logic        chk_err  [2];

  logic [31:0] rom [256];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mode    = 0;
  int          wcnt    [2] = '{0, 0};
  int          rbase   [2] = '{0, 0};
  int          stalls  [2] = '{0, 0};
  int          hold2   = 0;

  always #5 clk = ~clk;

  assign rom_q[0] = rom[rom_addr[0]];
  assign rom_q[1] = rom[rom_addr[1]];

  bios_loader #(.DATA_WIDTH(32), .ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(10),
                .WORD_COUNT(NW), .DEST_BASE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr[0]), .rom_q(rom_q[0]),
    .ram_we(ram_we[0]), .ram_ready(ready[0]), .ram_addr(ram_addr[0]),
    .ram_data(ram_data[0]), .cpu_hold(cpu_hold[0]), .done(done[0]),
    .chk_err(chk_err[0]));

  bios_loader #(.DATA_WIDTH(32), .ROM_ADDR_WIDTH(8), .RAM_ADDR_WIDTH(10),
                .WORD_COUNT(NW), .DEST_BASE(1022)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr[1]), .rom_q(rom_q[1]),
    .ram_we(ram_we[1]), .ram_ready(ready[1]), .ram_addr(ram_addr[1]),
    .ram_data(ram_data[1]), .cpu_hold(cpu_hold[1]), .done(done[1]),
    .chk_err(chk_err[1]));

  function automatic int base_of(input int k);
    return (k == 0) ? 0 : 1022;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM ready generator: 0 always ready, 1 random, 2 three-cycle stall on word 2 of instance 0
  initial begin
    int holdcnt;
    holdcnt  = 0;
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: begin
          ready[0] = ($urandom_range(0, 9) < 7);
          ready[1] = ($urandom_range(0, 9) < 7);
        end
        2: begin
          ready[1] = 1'b1;
          if (ram_we[0] && ram_addr[0] == 10'd2 && holdcnt < 3) begin
            ready[0] = 1'b0;
            holdcnt++;
          end else begin
            ready[0] = 1'b1;
            if (ram_addr[0] != 10'd2) holdcnt = 0;
          end
        end
        default: begin
          ready[0] = 1'b1;
          ready[1] = 1'b1;
        end
      endcase
    end
  end

  // Every cycle with a pending write must present the next expected word
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && ram_we[k]) begin
        int idx;
        logic [7:0] ri;
        idx = wcnt[k] - rbase[k];
        ri  = 8'(idx);
        check_eq($sformatf("waddr%0d_w%0d", k, idx), 64'(ram_addr[k]),
                 64'((base_of(k) + idx) % 1024));
        check_eq($sformatf("wdata%0d_w%0d", k, idx), 64'(ram_data[k]), 64'(rom[ri]));
        if (ready[k]) wcnt[k]++;
        else          stalls[k]++;
        if (k == 0 && ram_addr[0] == 10'd2) hold2++;
      end
    end
  end

  task automatic check_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq({tag, "_rom_addr"}, 64'(rom_addr[k]), 64'd0);
      check_eq({tag, "_ram_we"},   64'(ram_we[k]),   64'd0);
      check_eq({tag, "_ram_addr"}, 64'(ram_addr[k]), 64'd0);
      check_eq({tag, "_ram_data"}, 64'(ram_data[k]), 64'd0);
      check_eq({tag, "_cpu_hold"}, 64'(cpu_hold[k]), 64'd1);
      check_eq({tag, "_done"},     64'(done[k]),     64'd0);
      check_eq({tag, "_chk_err"},  64'(chk_err[k]),  64'd0);
    end
  endtask

  // One full load. launch 0: release reset; 1: pulse start. poke: extra start mid-load.
  task automatic run(input string tag, input int launch, input bit poke);
    int n;
    int cyc  [2];
    bit seen [2];
    int sb   [2];
    logic [31:0] sum;
    logic exp_err;
    sum     = rom[0] + rom[1] + rom[2] + rom[3];
    exp_err = (CHK != 0) && (rom[4] != sum);
    for (int k = 0; k < 2; k++) begin
      rbase[k] = wcnt[k];
      sb[k]    = stalls[k];
      seen[k]  = 1'b0;
      cyc[k]   = 0;
    end
    @(negedge clk);
    if (launch == 0) rst_n = 1'b1;
    else             start = 1'b1;
    n = 0;
    while (n < 200 && !(seen[0] && seen[1])) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1 || n == 4) start = 1'b0;
      if (poke && n == 3) start = 1'b1;
      if (n == 1 && launch == 1) begin
        for (int k = 0; k < 2; k++) begin
          check_eq({tag, "_done_clr"}, 64'(done[k]), 64'd0);
          check_eq({tag, "_hold_set"}, 64'(cpu_hold[k]), 64'd1);
        end
      end
      for (int k = 0; k < 2; k++)
        if (!seen[k] && done[k]) begin
          seen[k] = 1'b1;
          cyc[k]  = n;
        end
    end
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_finished%0d", tag, k), 64'(seen[k]), 64'd1);
      check_eq($sformatf("%s_cycles%0d", tag, k), 64'(cyc[k]),
               64'(2 + NW + CHK + (stalls[k] - sb[k])));
      check_eq($sformatf("%s_nwrites%0d", tag, k), 64'(wcnt[k] - rbase[k]), 64'(NW));
      check_eq($sformatf("%s_chk_err%0d", tag, k), 64'(chk_err[k]), 64'(exp_err));
      check_eq($sformatf("%s_cpu_hold%0d", tag, k), 64'(cpu_hold[k]), 64'(exp_err));
      check_eq($sformatf("%s_we_low%0d", tag, k), 64'(ram_we[k]), 64'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check_eq($sformatf("%s_done_stays%0d", tag, k), 64'(done[k]), 64'd1);
  endtask

  initial begin
    int h0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // Directed copy at power-up, matching checksum word
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44; rom[4] = 32'hAA;
    run("boot", 0, 1'b0);

    // RAM not ready for three cycles while word 2 is pending
    mode = 2;
    h0   = hold2;
    run("stall", 1, 1'b0);
    check_eq("stall_hold_cycles", 64'(hold2 - h0), 64'd4);

    // Wrong checksum word
    mode   = 0;
    rom[4] = 32'hAB;
    run("badsum", 1, 1'b0);

    // start during LOAD is ignored
    rom[4] = 32'hAA;
    run("poke", 1, 1'b1);

    // Reset after two accepted writes, then a full reload from word 0
    for (int k = 0; k < 2; k++) rbase[k] = wcnt[k];
    @(negedge clk);
    start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check_eq("pre_reset_writes", 64'(wcnt[0] - rbase[0]), 64'd2);
    rst_n = 1'b0;
    #1;
    check_reset("midload_reset");
    run("reload", 0, 1'b0);

    // Randomized ROM images, ready patterns and stray start pulses
    mode = 1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) rom[i] = $urandom;
      rom[4] = rom[0] + rom[1] + rom[2] + rom[3] + 32'($urandom_range(0, 1));
      run($sformatf("rand%0d", t), 1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
